qrange_gen: RTL and testbench
=============================

Name: qrange_gen

Overview:
- Parametrised nested-range generator: successor to the single-dimension range block.
- Consumes one configuration per transaction on a DTI consumer: NDIM triplets of {base, stop, incr}.
- Emits the full odometer sequence of all dimensions as a DTI queue of level NDIM.
- Adds over its predecessor: inclusive/exclusive stop mode, empty-range skip, optional registered output stage.

Parameters:
- NDIM, 2: number of nested dimensions (1..4); dim 0 innermost.
- W_START, 16: base width per dim.
- W_CNT, 16: stop width per dim.
- W_INCR, 16: increment width per dim.
- SIGNED, 0: 1 = base/stop/incr sign-extended to W_VAL; 0 = zero-extended.
- INCLUSIVE, 1: 1 = stop value is emitted; 0 = stop value is excluded.
- OUT_REG, 0: 1 = registered output through a full-throughput pipeline register.
- W_VAL, max(W_START,W_CNT): derived width of each output value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg  dti.consumer  NDIM*(W_INCR+W_CNT+W_START)  per-dim struct {incr, cnt, base}, base at LSB; dim 0 at LSBs.
- dout  dti.producer  NDIM*W_VAL+NDIM  {eot[NDIM-1:0], val[NDIM-1], ..., val[0]}; eot at MSBs.

Behaviour:
- State per dim: cur[d] (W_VAL). Plus a block-level started flag.
- Output value: val[d] = started ? cur[d] : base[d].
- Reset (rst low, asynchronous): cur = 0, started = 0, OUT_REG stage empty (dout.valid = 0).
- last[d]:
  - INCLUSIVE=1: val[d] == stop[d].
  - INCLUSIVE=0: val[d] + incr[d] == stop[d].
  - All comparisons are equality, modulo 2^W_VAL. An unreachable stop wraps indefinitely; this is a user error and is not detected.
- eot[k] = AND of last[0..k]. Final element of the transaction = eot[NDIM-1].
- Empty-range rule: INCLUSIVE=0 and base[d]==stop[d] for any d, while started==0.
  - Range is empty; no dout transaction is produced.
  - Generator presents dout.valid = 0 and cfg.ready = 1 for one cycle; the cfg is dropped.
- Handshake: hs = gen_valid & gen_ready; gen_valid = cfg.valid & ~empty.
- On hs:
  - Each dim d whose inner dims 0..d-1 are all last (always true for dim 0) loads base[d] if last[d], else val[d]+incr[d].
  - Other dims hold val[d].
  - started <= 1.
  - On the final element: started <= 0; cfg.ready = 1 in that cycle. cfg.ready is 0 for all other elements.
- Arithmetic: W_VAL-bit wrap-around addition; incr extended per SIGNED.
- OUT_REG=0:
  - dout.valid = gen_valid, combinational from cfg.valid.
  - Latency 0; no dout.ready -> dout.valid path.
- OUT_REG=1:
  - Generator feeds a 2-entry skid register; dout.valid and dout.data are registered.
  - Latency 1 cycle; sustained throughput 1 element/cycle under dout.ready=1.
  - cfg.ready is asserted when the final element enters the register.
- Backpressure: while dout.valid & ~dout.ready, dout.data is held stable.
- Stall and timing: cur/started change only on hs. A cfg.valid drop mid-transaction stalls the generator with no state loss. New cfg is usable the cycle after the final hs.
- Reset mid-transaction: counters and started clear, the OUT_REG stage is flushed, and the cfg is not consumed. If cfg is still valid, the sequence restarts from base.

Decomposition:
- Package qrange_pkg:
  - parametrised struct helpers for the dim cfg triplet {incr, cnt, base} and the dout layout;
  - max-width constant function;
  - SIGNED-aware extend function.
- One sub-module: dti_skid_reg (DATA_W parameter, 2-entry full-throughput register, asynchronous active-low rst). Instantiated only when OUT_REG=1.
- Per-dim counter logic stays in a generate loop; it is not a separate module.

Test Plan:
- NDIM=1, INCLUSIVE=1, base 0, stop 4, incr 1, dout.ready=1 -> vals 0,1,2,3,4; eot only on 4; cfg.ready pulses once with 4.
- NDIM=2, INCLUSIVE=1, inner base 10 stop 14 incr 2, outer base 0 stop 1 incr 1:
  - -> (0,10),(0,12),(0,14 eot=01),(1,10),(1,12),(1,14 eot=11); 6 transfers.
- NDIM=1, SIGNED=1, W=4, base 3, stop -3 (4'hD), incr -2 (4'hE) -> 3,1,-1,-3; eot on -3.
- INCLUSIVE=0, base 5, stop 5 -> cfg.ready high one cycle, dout.valid never asserted. Next cfg base 0 stop 3 incr 1 -> 0,1,2; eot on 2.
- Random dout.ready (50%) with OUT_REG=0 and 1, 2D config above:
  - -> identical sequence to the ready=1 run; data stable while stalled;
  - OUT_REG=1 at ready=1 gives 1 element/cycle after 1-cycle latency.
- Reset: assert rst low asynchronously after 2 transfers of the 1D 0..4 config, cfg held valid -> dout.valid=0 during reset; sequence restarts at 0 and completes 0..4.

Source files
------------

// File: rtl/qrange_pkg.sv
// Shared helpers for the nested-range generator: widths, field layout, extension.
// Pure functions and constants; no state, no latency.
// Not applicable: no handshake lives here.
package qrange_pkg;

    localparam int MAX_NDIM = 4;
    localparam int MAX_W    = 64;

    // Larger of two widths; used to derive the output value width.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of one dim cfg triplet {incr, cnt, base}, base at LSB.
    function automatic int dim_cfg_w(input int w_start, input int w_cnt, input int w_incr);
        return w_start + w_cnt + w_incr;
    endfunction

    // Bit offsets of the fields inside one dim cfg triplet.
    function automatic int cnt_lsb(input int w_start);
        return w_start;
    endfunction

    function automatic int incr_lsb(input int w_start, input int w_cnt);
        return w_start + w_cnt;
    endfunction

    // Output word: {eot[ndim-1:0], val[ndim-1], ..., val[0]}.
    function automatic int dout_w(input int ndim, input int w_val);
        return ndim * w_val + ndim;
    endfunction

    // Extend the low w bits of v to MAX_W, sign- or zero-filling above.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v, input int w, input bit sgn);
        logic [MAX_W-1:0] t;
        t = v << (MAX_W - w);
        if (sgn) return MAX_W'($signed(t) >>> (MAX_W - w));
        return t >> (MAX_W - w);
    endfunction

endpackage

// File: rtl/qrange_gen_if.sv
// Valid/ready stream bundle carrying one packed data word per transfer.
// No latency of its own.
// A transfer happens on a clock edge where valid and ready are both high.
interface qrange_gen_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master   (output valid, output data, input  ready);
    modport slave    (input  valid, input  data, output ready);
    modport producer (output valid, output data, input  ready);
    modport consumer (input  valid, input  data, output ready);
endinterface

// File: rtl/dti_skid_reg.sv
// Two-entry pipeline register giving registered valid/data at full throughput.
// Latency 1 cycle.
// up_ready is registered (skid empty), so no combinational path from dn_ready.
module dti_skid_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);
    logic              main_vld;
    logic              skid_vld;
    logic [DATA_W-1:0] main_dat;
    logic [DATA_W-1:0] skid_dat;

    assign up_ready = ~skid_vld;
    assign dn_valid = main_vld;
    assign dn_data  = main_dat;

    // Occupancy: main refills from skid first, skid only catches data during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || dn_ready) begin
            if (skid_vld) begin
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= up_valid;
            end
        end else if (up_valid && !skid_vld) begin
            skid_vld <= 1'b1;
        end
    end

    // Payload registers follow the occupancy decisions; main is untouched while stalled.
    always_ff @(posedge clk) begin
        if (!main_vld || dn_ready) main_dat <= skid_vld ? skid_dat : up_data;
        if (main_vld && !dn_ready && !skid_vld) skid_dat <= up_data;
    end
endmodule

// File: rtl/qrange_gen.sv
// Nested odometer range generator: one cfg of NDIM {base,stop,incr} -> full sequence.
// Latency 0 (OUT_REG=0) or 1 cycle (OUT_REG=1), one element per cycle.
// Stalls on dout.ready low or cfg.valid low without state loss; cfg.ready only on final element.
module qrange_gen
    import qrange_pkg::*;
#(
    parameter int NDIM      = 2,
    parameter int W_START   = 16,
    parameter int W_CNT     = 16,
    parameter int W_INCR    = 16,
    parameter int SIGNED    = 0,
    parameter int INCLUSIVE = 1,
    parameter int OUT_REG   = 0,
    parameter int W_VAL     = max_w(W_START, W_CNT)
) (
    input  logic         clk,
    input  logic         rst,
    qrange_gen_if.slave  cfg,
    qrange_gen_if.master dout
);
    localparam int DW = dim_cfg_w(W_START, W_CNT, W_INCR);
    localparam int OW = dout_w(NDIM, W_VAL);

    logic [W_VAL-1:0] base_v [NDIM];
    logic [W_VAL-1:0] stop_v [NDIM];
    logic [W_VAL-1:0] incr_v [NDIM];
    logic [W_VAL-1:0] val    [NDIM];
    logic [W_VAL-1:0] nxt    [NDIM];
    logic [NDIM-1:0]  last;
    logic [NDIM-1:0]  eot;
    logic [NDIM-1:0]  adv;
    logic [NDIM-1:0]  base_is_stop;
    logic             started;
    logic             empty;
    logic             gen_valid;
    logic             gen_ready;
    logic             hs;
    logic [OW-1:0]    gen_data;

    for (genvar d = 0; d < NDIM; d++) begin : g_dim
        logic [W_VAL-1:0] cur_q;

        assign base_v[d] = W_VAL'(extend(MAX_W'(cfg.data[d*DW +: W_START]), W_START, SIGNED != 0));
        assign stop_v[d] = W_VAL'(extend(MAX_W'(cfg.data[d*DW + cnt_lsb(W_START) +: W_CNT]), W_CNT, SIGNED != 0));
        assign incr_v[d] = W_VAL'(extend(MAX_W'(cfg.data[d*DW + incr_lsb(W_START, W_CNT) +: W_INCR]), W_INCR, SIGNED != 0));

        assign val[d]          = started ? cur_q : base_v[d];
        assign nxt[d]          = val[d] + incr_v[d];
        assign last[d]         = (INCLUSIVE != 0) ? (val[d] == stop_v[d]) : (nxt[d] == stop_v[d]);
        assign base_is_stop[d] = (base_v[d] == stop_v[d]);
        assign gen_data[d*W_VAL +: W_VAL] = val[d];

        // A dim steps only when every inner dim wraps; wrapping reloads base.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)    cur_q <= '0;
            else if (hs) cur_q <= !adv[d] ? val[d] : (last[d] ? base_v[d] : nxt[d]);
        end
    end

    // Prefix-AND of last: adv[d] = all inner dims last, eot[d] includes dim d itself.
    always_comb begin
        logic acc;
        acc = 1'b1;
        adv = '0;
        eot = '0;
        for (int d = 0; d < NDIM; d++) begin
            adv[d] = acc;
            acc    = acc & last[d];
            eot[d] = acc;
        end
    end

    assign gen_data[NDIM*W_VAL +: NDIM] = eot;

    // An exclusive range starting at its stop has nothing to emit; it is accepted and dropped.
    // Reset gates both directions so nothing is emitted or consumed while it is held.
    assign empty     = (INCLUSIVE == 0) && !started && (|base_is_stop);
    assign gen_valid = rst & cfg.valid & ~empty;
    assign hs        = gen_valid & gen_ready;
    assign cfg.ready = rst & (empty | (hs & eot[NDIM-1]));

    // started distinguishes the first element (taken from base) from later ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    started <= 1'b0;
        else if (hs) started <= ~eot[NDIM-1];
    end

    if (OUT_REG != 0) begin : g_reg
        dti_skid_reg #(
            .DATA_W (OW)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .up_valid (gen_valid),
            .up_ready (gen_ready),
            .up_data  (gen_data),
            .dn_valid (dout.valid),
            .dn_ready (dout.ready),
            .dn_data  (dout.data)
        );
    end else begin : g_comb
        assign dout.valid = gen_valid;
        assign dout.data  = gen_data;
        assign gen_ready  = dout.ready;
    end
endmodule

// File: tb/tb_qrange_gen.sv
// Scoreboard bench: three generator variants (2D comb, 2D registered, 1D signed exclusive).
// Expected elements come from a list-based odometer model and are checked by per-instance monitors.
// Random dout.ready exercises stalls; data must hold while stalled.
module tb_qrange_gen;
    typedef logic [33:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    qrange_gen_if #(.DATA_W(96)) x_cfg ();
    qrange_gen_if #(.DATA_W(34)) x_dout ();
    qrange_gen_if #(.DATA_W(96)) y_cfg ();
    qrange_gen_if #(.DATA_W(34)) y_dout ();
    qrange_gen_if #(.DATA_W(12)) z_cfg ();
    qrange_gen_if #(.DATA_W(5))  z_dout ();

    qrange_gen #(.NDIM(2), .W_START(16), .W_CNT(16), .W_INCR(16), .SIGNED(0), .INCLUSIVE(1), .OUT_REG(0))
        u_x (.clk(clk), .rst(rst), .cfg(x_cfg), .dout(x_dout));
    qrange_gen #(.NDIM(2), .W_START(16), .W_CNT(16), .W_INCR(16), .SIGNED(0), .INCLUSIVE(1), .OUT_REG(1))
        u_y (.clk(clk), .rst(rst), .cfg(y_cfg), .dout(y_dout));
    qrange_gen #(.NDIM(1), .W_START(4), .W_CNT(4), .W_INCR(4), .SIGNED(1), .INCLUSIVE(0), .OUT_REG(0))
        u_z (.clk(clk), .rst(rst), .cfg(z_cfg), .dout(z_dout));

    word_t q0[$];
    word_t q1[$];
    word_t q2[$];
    word_t mq[$];
    bit    rnd_mode [3];
    bit    prev_stall [3];
    word_t prev_w [3];
    int    xfers [3];

    task automatic check(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int qsz(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic word_t qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic qpush_model(input int i);
        foreach (mq[k]) begin
            case (i)
                0:       q0.push_back(mq[k]);
                1:       q1.push_back(mq[k]);
                default: q2.push_back(mq[k]);
            endcase
        end
    endtask

    // Reference: list each dim's values from base to stop, then walk their cartesian product
    // with dim 0 fastest; eot[k] marks elements where dims 0..k are all at their final entry.
    task automatic build_model(input int nd, input int w, input int incl,
                               input int b[4], input int s[4], input int c[4]);
        int    len [4];
        int    lst [4][64];
        int    idx [4];
        int    m;
        int    v;
        bit    fin;
        bit    all_last;
        word_t wd;
        m = (1 << w) - 1;
        mq.delete();
        for (int d = 0; d < nd; d++) begin
            len[d] = 0;
            idx[d] = 0;
            v = b[d] & m;
            for (int k = 0; k < 64; k++) begin
                if (incl == 0 && v == (s[d] & m)) break;
                lst[d][len[d]] = v;
                len[d]++;
                if (incl != 0 && v == (s[d] & m)) break;
                v = (v + c[d]) & m;
            end
            if (len[d] == 0) return;
        end
        fin = 1'b0;
        while (!fin) begin
            wd = '0;
            for (int d = 0; d < nd; d++) wd[16*d +: 16] = 16'(lst[d][idx[d]]);
            for (int k = 0; k < nd; k++) begin
                all_last = 1'b1;
                for (int d = 0; d <= k; d++) if (idx[d] != len[d] - 1) all_last = 1'b0;
                wd[32+k] = all_last;
            end
            mq.push_back(wd);
            fin = 1'b1;
            for (int d = 0; d < nd; d++) begin
                if (idx[d] + 1 < len[d]) begin
                    idx[d]++;
                    fin = 1'b0;
                    break;
                end
                idx[d] = 0;
            end
        end
    endtask

    function automatic logic [95:0] pack_cfg(input int i, input int b[4], input int s[4], input int c[4]);
        logic [95:0] dat;
        dat = '0;
        if (i == 2) dat[11:0] = {4'(c[0]), 4'(s[0]), 4'(b[0])};
        else for (int d = 0; d < 2; d++) dat[48*d +: 48] = {16'(c[d]), 16'(s[d]), 16'(b[d])};
        return dat;
    endfunction

    task automatic set_cfg(input int i, input logic v, input logic [95:0] dat);
        case (i)
            0:       begin x_cfg.valid = v; x_cfg.data = dat;        end
            1:       begin y_cfg.valid = v; y_cfg.data = dat;        end
            default: begin z_cfg.valid = v; z_cfg.data = dat[11:0]; end
        endcase
    endtask

    function automatic logic cfg_ready(input int i);
        case (i)
            0:       return x_cfg.ready;
            1:       return y_cfg.ready;
            default: return z_cfg.ready;
        endcase
    endfunction

    function automatic logic dout_valid(input int i);
        case (i)
            0:       return x_dout.valid;
            1:       return y_dout.valid;
            default: return z_dout.valid;
        endcase
    endfunction

    function automatic logic dout_eot_top(input int i);
        case (i)
            0:       return x_dout.data[33];
            1:       return y_dout.data[33];
            default: return z_dout.data[4];
        endcase
    endfunction

    task automatic rand_cfg(input int w, input int nmax, output int b[4], output int s[4], output int c[4]);
        int m;
        m = (1 << w) - 1;
        for (int d = 0; d < 4; d++) begin
            b[d] = int'($urandom) & m;
            c[d] = int'($urandom_range(1, m));
            s[d] = (b[d] + int'($urandom_range(0, nmax)) * c[d]) & m;
        end
    endtask

    // Drive one cfg until the DUT accepts it; expected elements are queued up front.
    task automatic send(input int i, input int b[4], input int s[4], input int c[4]);
        bit exp_empty;
        bit done;
        logic [95:0] dat;
        build_model((i == 2) ? 1 : 2, (i == 2) ? 4 : 16, (i == 2) ? 0 : 1, b, s, c);
        exp_empty = (mq.size() == 0);
        qpush_model(i);
        dat = pack_cfg(i, b, s, c);
        @(posedge clk); #1;
        set_cfg(i, 1'b1, dat);
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (exp_empty && n == 0) begin
                check(cfg_ready(i) == 1'b1, $sformatf("empty_cfg_ready%0d", i), cfg_ready(i), 1);
                check(dout_valid(i) == 1'b0, $sformatf("empty_dout_valid%0d", i), dout_valid(i), 0);
            end
            if (cfg_ready(i)) begin
                done = 1'b1;
                if (!exp_empty && i != 1)
                    check(dout_eot_top(i) == 1'b1, $sformatf("final_eot%0d", i), dout_eot_top(i), 1);
            end
        end
        check(done, $sformatf("cfg_accept%0d", i), done, 1);
        @(posedge clk); #1;
        set_cfg(i, 1'b0, dat);
    endtask

    task automatic drain(input int i);
        for (int n = 0; n < 2000 && qsz(i) != 0; n++) @(negedge clk);
        check(qsz(i) == 0, $sformatf("drain%0d", i), qsz(i), 0);
    endtask

    task automatic mon(input int i, input logic v, input logic r, input word_t w);
        word_t e;
        if (!rst) begin
            prev_stall[i] = 1'b0;
            return;
        end
        if (prev_stall[i]) begin
            check(v == 1'b1, $sformatf("hold_valid%0d", i), v, 1);
            check(w == prev_w[i], $sformatf("hold_data%0d", i), w, prev_w[i]);
        end
        if (v && r) begin
            check(qsz(i) > 0, $sformatf("expected_pending%0d", i), qsz(i), 1);
            if (qsz(i) > 0) begin
                e = qpop(i);
                check(w == e, $sformatf("element%0d", i), w, e);
            end
            xfers[i]++;
        end
        prev_stall[i] = v && !r;
        prev_w[i] = w;
    endtask

    always @(negedge clk) mon(0, x_dout.valid, x_dout.ready, x_dout.data);
    always @(negedge clk) mon(1, y_dout.valid, y_dout.ready, y_dout.data);
    always @(negedge clk) mon(2, z_dout.valid, z_dout.ready, {1'b0, z_dout.data[4], 16'h0, 12'h0, z_dout.data[3:0]});

    // Sink readiness: always ready, or a fair coin per cycle.
    always @(posedge clk) begin
        #1;
        x_dout.ready = rnd_mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
        y_dout.ready = rnd_mode[1] ? 1'($urandom_range(0, 1)) : 1'b1;
        z_dout.ready = rnd_mode[2] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        int b[4];
        int s[4];
        int c[4];
        int start;
        bit cons;
        bit done;
        logic [95:0] dat;

        for (int i = 0; i < 3; i++) begin
            rnd_mode[i] = 1'b0;
            prev_stall[i] = 1'b0;
            xfers[i] = 0;
        end
        set_cfg(0, 1'b0, '0);
        set_cfg(1, 1'b0, '0);
        set_cfg(2, 1'b0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(y_dout.valid == 1'b0, "reset_y_valid", y_dout.valid, 0);
        check(x_dout.valid == 1'b0, "reset_x_valid", x_dout.valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check(y_dout.valid == 1'b0, "idle_y_valid", y_dout.valid, 0);
        check(z_dout.valid == 1'b0, "idle_z_valid", z_dout.valid, 0);

        // 2D inclusive, sink always ready, then the same cfg under random stalls
        b = '{10, 0, 0, 0}; s = '{14, 1, 0, 0}; c = '{2, 1, 0, 0};
        send(0, b, s, c);
        drain(0);
        rnd_mode[0] = 1'b1;
        send(0, b, s, c);
        drain(0);
        for (int t = 0; t < 6; t++) begin
            rand_cfg(16, 3, b, s, c);
            send(0, b, s, c);
            drain(0);
        end

        // Registered output: 1-cycle latency, one element per cycle, cfg.ready with the final element
        b = '{10, 0, 0, 0}; s = '{14, 1, 0, 0}; c = '{2, 1, 0, 0};
        build_model(2, 16, 1, b, s, c);
        qpush_model(1);
        dat = pack_cfg(1, b, s, c);
        @(posedge clk); #1;
        set_cfg(1, 1'b1, dat);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check(y_dout.valid == (k != 0), $sformatf("y_valid_cycle%0d", k), y_dout.valid, k != 0);
            if (k < 6) check(y_cfg.ready == (k == 5), $sformatf("y_cfg_ready_cycle%0d", k), y_cfg.ready, k == 5);
            cons = y_cfg.ready && y_cfg.valid;
            @(posedge clk); #1;
            if (cons) set_cfg(1, 1'b0, dat);
        end
        drain(1);
        rnd_mode[1] = 1'b1;
        send(1, b, s, c);
        drain(1);
        for (int t = 0; t < 6; t++) begin
            rand_cfg(16, 3, b, s, c);
            send(1, b, s, c);
            drain(1);
        end

        // Signed exclusive 1D: 3,1,-1,-3 then an empty range, then 0,1,2
        b = '{3, 0, 0, 0}; s = '{11, 0, 0, 0}; c = '{14, 0, 0, 0};
        send(2, b, s, c);
        drain(2);
        b = '{5, 0, 0, 0}; s = '{5, 0, 0, 0}; c = '{1, 0, 0, 0};
        send(2, b, s, c);
        b = '{0, 0, 0, 0}; s = '{3, 0, 0, 0}; c = '{1, 0, 0, 0};
        send(2, b, s, c);
        drain(2);
        rnd_mode[2] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            rand_cfg(4, 4, b, s, c);
            send(2, b, s, c);
            drain(2);
        end

        // Reset mid-transaction with cfg held valid: restart from base and complete
        rnd_mode[0] = 1'b0;
        b = '{0, 0, 0, 0}; s = '{4, 0, 0, 0}; c = '{1, 1, 0, 0};
        build_model(2, 16, 1, b, s, c);
        qpush_model(0);
        dat = pack_cfg(0, b, s, c);
        start = xfers[0];
        @(posedge clk); #1;
        set_cfg(0, 1'b1, dat);
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            if (xfers[0] >= start + 2) done = 1'b1;
        end
        check(done, "rst_two_transfers", xfers[0] - start, 2);
        #3;
        rst = 1'b0;
        q0.delete();
        qpush_model(0);
        @(negedge clk);
        check(x_dout.valid == 1'b0, "rst_hold_dout_valid", x_dout.valid, 0);
        check(x_cfg.ready == 1'b0, "rst_hold_cfg_ready", x_cfg.ready, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (x_cfg.ready) done = 1'b1;
        end
        check(done, "rst_restart_accept", done, 1);
        @(posedge clk); #1;
        set_cfg(0, 1'b0, dat);
        drain(0);
        drain(1);
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
